rom_ctrl_mux_nway: RTL and testbench

//  N-client, one-way ROM access mux; next generation of the two-way checker/bus mux.

---
 rtl/rom_ctrl_mux_nway.sv | 182 ++++++++++++++++++
 tb/tb_rom_ctrl_mux_nway.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ctrl_mux_nway.sv
// N-client one-way ROM access mux: ownership only moves from client 0 towards client NumClients-1.
// Optional define ROM_CTRL_MUX_SHADOW_EN adds an inverted shadow of the owner index with integrity alerts.

`ifdef ROM_CTRL_MUX_SHADOW_EN
// Plain reset flop kept as a separate instance so the shadow copy is not merged with the owner register.
module rom_ctrl_mux_nway_flop #(
  parameter int unsigned Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] q_r;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_r <= ResetValue;
    end else begin
      q_r <= d_i;
    end
  end

  assign q_o = q_r;
endmodule
`endif

module rom_ctrl_mux_nway #(
  parameter int unsigned AW             = 8,
  parameter int unsigned DW             = 39,
  parameter int unsigned NumClients     = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [3:0]                    advance_i,
  input  logic [NumClients-1:0]         req_i,
  input  logic [NumClients*AW-1:0]      addr_i,
  output logic [NumClients-1:0]         gnt_o,
  output logic [NumClients-1:0]         rvalid_o,
  output logic [NumClients*DW-1:0]      rdata_o,
  output logic                          rom_req_o,
  output logic [AW-1:0]                 rom_addr_o,
  input  logic [DW-1:0]                 rom_scr_rdata_i,
  input  logic [DW-1:0]                 rom_clr_rdata_i,
  input  logic                          rom_rvalid_i,
  output logic [$clog2(NumClients)-1:0] owner_o,
  output logic                          alert_o
);
  localparam int unsigned OW = $clog2(NumClients);
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  logic [OW-1:0] owner_r;
  logic [OW-1:0] owner_next_s;
  logic          alert_r;
  logic [OW-1:0] tag_mem_r [MaxOutstanding];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic                     full_s;
  logic                     empty_s;
  logic                     can_issue_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     orphan_s;
  logic                     adv_true_s;
  logic                     adv_bad_s;
  logic                     shadow_bad_s;
  logic [OW-1:0]            head_s;
  logic [NumClients-1:0]    gnt_s;
  logic [NumClients-1:0]    rvalid_s;
  logic [AW-1:0]            addr_sel_s;
  logic [NumClients*DW-1:0] rdata_s;

  assign full_s      = (count_r == CW'(MaxOutstanding));
  assign empty_s     = (count_r == {CW{1'b0}});
  // A response retiring this cycle frees a slot, so a full FIFO may still accept one issue.
  assign can_issue_s = !full_s || rom_rvalid_i;
  assign head_s      = tag_mem_r[rd_ptr_r];
  assign push_s      = |gnt_s;
  assign pop_s       = rom_rvalid_i && !empty_s;
  assign orphan_s    = rom_rvalid_i && empty_s;
  assign adv_true_s  = (advance_i == MuBi4True);
  assign adv_bad_s   = (advance_i != MuBi4True) && (advance_i != MuBi4False);

  // Grant, address select, response routing and data fan-out
  always_comb begin
    gnt_s      = {NumClients{1'b0}};
    rvalid_s   = {NumClients{1'b0}};
    addr_sel_s = {AW{1'b0}};
    rdata_s    = {(NumClients*DW){1'b0}};
    for (int k = 0; k < NumClients; k++) begin
      gnt_s[k]    = (owner_r == OW'(k)) && req_i[k] && can_issue_s;
      rvalid_s[k] = pop_s && (head_s == OW'(k));
      addr_sel_s  = addr_sel_s | ({AW{owner_r == OW'(k)}} & addr_i[k*AW +: AW]);
      rdata_s[k*DW +: DW] = (k == 0) ? rom_scr_rdata_i : rom_clr_rdata_i;
    end
  end

  // Next owner: saturates at the last client
  always_comb begin
    if (adv_true_s && (owner_r < OW'(NumClients - 1))) begin
      owner_next_s = owner_r + OW'(1);
    end else begin
      owner_next_s = owner_r;
    end
  end

`ifdef ROM_CTRL_MUX_SHADOW_EN
  logic [OW-1:0] owner_shadow_s;

  rom_ctrl_mux_nway_flop #(
    .Width      (OW),
    .ResetValue ({OW{1'b1}})
  ) u_shadow_flop (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (~owner_next_s),
    .q_o    (owner_shadow_s)
  );

  assign shadow_bad_s = (owner_shadow_s != ~owner_r) ||
                        ({1'b0, owner_r} >= (OW+1)'(NumClients));
`else
  assign shadow_bad_s = 1'b0;
`endif

  // Owner and sticky alert
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_r <= {OW{1'b0}};
      alert_r <= 1'b0;
    end else begin
      owner_r <= owner_next_s;
      alert_r <= alert_r | adv_bad_s | orphan_s | shadow_bad_s;
    end
  end

  // Tag FIFO of issuing owners, one entry per in-flight read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        tag_mem_r[i] <= {OW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= owner_r;
        wr_ptr_r <= (wr_ptr_r == PW'(MaxOutstanding - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(MaxOutstanding - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign gnt_o      = gnt_s;
  assign rvalid_o   = rvalid_s;
  assign rdata_o    = rdata_s;
  assign rom_req_o  = push_s;
  assign rom_addr_o = addr_sel_s;
  assign owner_o    = owner_r;
  assign alert_o    = alert_r;

endmodule

// File: tb/tb_rom_ctrl_mux_nway.sv
// Directed bench for rom_ctrl_mux_nway (3 clients, 2 outstanding) with a queue-based reference model.
// Shadow-fault stimulus is applied only when ROM_CTRL_MUX_SHADOW_EN is defined.
module tb_rom_ctrl_mux_nway;
  localparam int AW = 8;
  localparam int DW = 39;
  localparam int NC = 3;
  localparam int MO = 2;
  localparam int OW = 2;
  localparam logic [3:0] T = 4'h6;
  localparam logic [3:0] F = 4'h9;
  localparam logic [DW-1:0] SCR = 39'h12_3456_789A;
  localparam logic [DW-1:0] CLR = 39'h70_F0F0_0F0F;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [3:0]       advance_i;
  logic [NC-1:0]    req_i;
  logic [NC*AW-1:0] addr_i;
  logic [NC-1:0]    gnt_o;
  logic [NC-1:0]    rvalid_o;
  logic [NC*DW-1:0] rdata_o;
  logic             rom_req_o;
  logic [AW-1:0]    rom_addr_o;
  logic [DW-1:0]    rom_scr_rdata_i;
  logic [DW-1:0]    rom_clr_rdata_i;
  logic             rom_rvalid_i;
  logic [OW-1:0]    owner_o;
  logic             alert_o;

  rom_ctrl_mux_nway #(.AW(AW), .DW(DW), .NumClients(NC), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .advance_i(advance_i), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rom_req_o(rom_req_o),
    .rom_addr_o(rom_addr_o), .rom_scr_rdata_i(rom_scr_rdata_i), .rom_clr_rdata_i(rom_clr_rdata_i),
    .rom_rvalid_i(rom_rvalid_i), .owner_o(owner_o), .alert_o(alert_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int m_owner = 0;
  int m_q[$];
  bit m_alert = 1'b0;
  bit fault_inj = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index, queue of issuer tags, sticky alert
  initial begin
    logic [NC-1:0] eg, er;
    logic [AW-1:0] ea;
    bit full, empty;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_owner = 0;
        m_q.delete();
        m_alert = 1'b0;
      end
      full  = (m_q.size() == MO);
      empty = (m_q.size() == 0);
      eg = '0;
      if (req_i[m_owner] && (!full || rom_rvalid_i)) eg[m_owner] = 1'b1;
      ea = addr_i[m_owner*AW +: AW];
      er = '0;
      if (rom_rvalid_i && !empty) er[m_q[0]] = 1'b1;
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("rom_req", 64'(rom_req_o), 64'(|eg));
      chk("rom_addr", 64'(rom_addr_o), 64'(ea));
      chk("rvalid", 64'(rvalid_o), 64'(er));
      chk("owner", 64'(owner_o), 64'(m_owner));
      chk("alert", 64'(alert_o), 64'(m_alert));
      for (int k = 0; k < NC; k++)
        chk("rdata", 64'(rdata_o[k*DW +: DW]), 64'((k == 0) ? rom_scr_rdata_i : rom_clr_rdata_i));
      if (rst_ni) begin
        if ((advance_i != T && advance_i != F) || (rom_rvalid_i && empty) || fault_inj) m_alert = 1'b1;
        if (rom_rvalid_i && !empty) void'(m_q.pop_front());
        if (|eg) m_q.push_back(m_owner);
        if (advance_i == T && m_owner < NC - 1) m_owner++;
      end
    end
  end

  task automatic set(input logic [NC-1:0] r, input logic [3:0] a, input logic rv);
    req_i = r;
    advance_i = a;
    rom_rvalid_i = rv;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set('0, F, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_alert", 64'(alert_o), 64'h0);
    chk("rst_owner", 64'(owner_o), 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    addr_i = {8'h33, 8'h22, 8'h11};
    rom_scr_rdata_i = SCR;
    rom_clr_rdata_i = CLR;
    set('0, F, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_rom_req", 64'(rom_req_o), 64'h0);
    chk("rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("rst_owner", 64'(owner_o), 64'h0);
    chk("rst_alert", 64'(alert_o), 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick();

    // Single read by client 0, response one cycle later
    addr_i[7:0] = 8'h12;
    set(3'b001, F, 1'b0);
    @(negedge clk_i);
    chk("s1_gnt", 64'(gnt_o), 64'h1);
    chk("s1_addr", 64'(rom_addr_o), 64'h12);
    tick();
    set(3'b000, F, 1'b1);
    @(negedge clk_i);
    chk("s1_rvalid", 64'(rvalid_o), 64'h1);
    chk("s1_rdata", 64'(rdata_o[DW-1:0]), 64'(SCR));
    tick();

    // Two reads as client 0, hand over on the second; both responses stay with client 0
    addr_i[7:0] = 8'h20;
    set(3'b001, F, 1'b0);
    tick();
    addr_i[7:0] = 8'h21;
    set(3'b001, T, 1'b0);
    @(negedge clk_i);
    chk("s2_gnt", 64'(gnt_o), 64'h1);
    chk("s2_owner_old", 64'(owner_o), 64'h0);
    tick();
    set(3'b000, F, 1'b1);
    @(negedge clk_i);
    chk("s2_rvalid_a", 64'(rvalid_o), 64'h1);
    chk("s2_owner_new", 64'(owner_o), 64'h1);
    tick();
    @(negedge clk_i);
    chk("s2_rvalid_b", 64'(rvalid_o), 64'h1);
    tick();

    // Client 1 fills the tag FIFO; third request waits unless a response retires
    addr_i[15:8] = 8'h30;
    rom_clr_rdata_i = 39'h55_AAAA_5555;
    set(3'b010, F, 1'b0);
    @(negedge clk_i);
    chk("s3_gnt1", 64'(gnt_o), 64'h2);
    tick();
    @(negedge clk_i);
    chk("s3_gnt2", 64'(gnt_o), 64'h2);
    tick();
    @(negedge clk_i);
    chk("s3_full", 64'(gnt_o), 64'h0);
    tick();
    set(3'b010, F, 1'b1);
    @(negedge clk_i);
    chk("s3_gnt_pop", 64'(gnt_o), 64'h2);
    chk("s3_rvalid", 64'(rvalid_o), 64'h2);
    tick();
    set(3'b000, F, 1'b1);
    repeat (2) tick();
    set(3'b101, F, 1'b0);
    @(negedge clk_i);
    chk("s3_nonowner", 64'(gnt_o), 64'h0);
    tick();

    // Advance to the last client, then saturate
    set(3'b000, T, 1'b0);
    repeat (2) tick();
    set(3'b000, F, 1'b0);
    @(negedge clk_i);
    chk("s5_owner", 64'(owner_o), 64'h2);
    chk("s5_alert", 64'(alert_o), 64'h0);
    tick();

    // Invalid advance encoding: alert next cycle, sticky until reset
    set(3'b000, 4'b0000, 1'b0);
    @(negedge clk_i);
    chk("s6_owner", 64'(owner_o), 64'h2);
    chk("s6_alert_now", 64'(alert_o), 64'h0);
    tick();
    set(3'b000, F, 1'b0);
    @(negedge clk_i);
    chk("s6_alert", 64'(alert_o), 64'h1);
    repeat (3) tick();
    @(negedge clk_i);
    chk("s6_sticky", 64'(alert_o), 64'h1);
    tick();
    do_reset();

    // Reset with a read in flight: the late response is an orphan
    addr_i[7:0] = 8'h40;
    set(3'b001, F, 1'b0);
    tick();
    set(3'b000, F, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    set(3'b000, F, 1'b1);
    @(negedge clk_i);
    chk("s7_rvalid", 64'(rvalid_o), 64'h0);
    tick();
    set(3'b000, F, 1'b0);
    @(negedge clk_i);
    chk("s7_alert", 64'(alert_o), 64'h1);
    tick();
    do_reset();

`ifdef ROM_CTRL_MUX_SHADOW_EN
    force dut.u_shadow_flop.q_r = 2'b10;
    fault_inj = 1'b1;
    tick();
    release dut.u_shadow_flop.q_r;
    fault_inj = 1'b0;
    @(negedge clk_i);
    chk("s8_shadow_alert", 64'(alert_o), 64'h1);
    tick();
`else
    repeat (3) tick();
    @(negedge clk_i);
    chk("s8_no_shadow_alert", 64'(alert_o), 64'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
